// File: rtl/jt12_tick_timer_pkg.sv
// Shared widths and helpers for the OPN interval timers.
package jt12_tick_timer_pkg;

  localparam int unsigned TA_W       = 10;
  localparam int unsigned TB_W       = 8;
  localparam int unsigned B_PRES_DEF = 16;

  // Prescaler register width; keeps at least one bit for degenerate lengths.
  function automatic int unsigned pres_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jt12_tick_cnt.sv
// Up-counting interval timer: load-edge reload, terminal-count reload,
// overflow pulse and sticky, clearable status flag.
module jt12_tick_cnt
  import jt12_tick_timer_pkg::*;
#(
  parameter int unsigned W = TA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en_irq,
  input  logic         clr_flag,
  output logic         load_edge,
  output logic         ovf,
  output logic         flag
);

  localparam logic [W-1:0] TERM = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         load_q;
  logic         ovf_q, ovf_d;
  logic         flag_q, flag_d;

  always_comb begin
    load_edge = load & ~load_q;
    cnt_d     = cnt_q;
    ovf_d     = 1'b0;
    // A load edge wins over a coincident tick: reload only, no increment.
    if (load_edge) begin
      cnt_d = value;
    end else if (load && tick) begin
      if (cnt_q == TERM) begin
        cnt_d = value;
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    flag_d = flag_q;
    if (clr_flag)        flag_d = 1'b0;
    if (ovf_d && en_irq) flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      load_q <= 1'b0;
      ovf_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      load_q <= load;
      ovf_q  <= ovf_d;
      flag_q <= flag_d;
    end
  end

  assign ovf  = ovf_q;
  assign flag = flag_q;

endmodule

// File: rtl/jt12_tick_timer.sv
// OPN Timer A (10-bit) and Timer B (8-bit behind a prescaler), with status
// flags, registered active-low IRQ and a Timer A overflow pulse for CSM.
module jt12_tick_timer
  import jt12_tick_timer_pkg::*;
#(
  parameter int unsigned B_PRES = B_PRES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic [TA_W-1:0] value_A,
  input  logic [TB_W-1:0] value_B,
  input  logic            load_A,
  input  logic            load_B,
  input  logic            en_irq_A,
  input  logic            en_irq_B,
  input  logic            clr_flag_A,
  input  logic            clr_flag_B,
  output logic            flag_A,
  output logic            flag_B,
  output logic            overflow_A,
  output logic            irq_n
);

  localparam int unsigned    PW        = pres_w(B_PRES);
  localparam logic [PW-1:0]  PRES_LAST = PW'(B_PRES - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          irq_n_q, irq_n_d;
  logic          tick_b;
  logic          load_edge_b;
  logic          load_edge_a_unused;
  logic          ovf_b_unused;

  jt12_tick_cnt #(.W(TA_W)) u_timer_a (
    .clk       (clk),
    .rst       (rst),
    .tick      (clk_en),
    .load      (load_A),
    .value     (value_A),
    .en_irq    (en_irq_A),
    .clr_flag  (clr_flag_A),
    .load_edge (load_edge_a_unused),
    .ovf       (overflow_A),
    .flag      (flag_A)
  );

  always_comb begin
    presc_d = presc_q;
    tick_b  = 1'b0;
    if (load_edge_b) begin
      presc_d = '0;
    end else if (load_B && clk_en) begin
      if (presc_q == PRES_LAST) begin
        presc_d = '0;
        tick_b  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    irq_n_d = ~(flag_A | flag_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      irq_n_q <= 1'b1;
    end else begin
      presc_q <= presc_d;
      irq_n_q <= irq_n_d;
    end
  end

  jt12_tick_cnt #(.W(TB_W)) u_timer_b (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick_b),
    .load      (load_B),
    .value     (value_B),
    .en_irq    (en_irq_B),
    .clr_flag  (clr_flag_B),
    .load_edge (load_edge_b),
    .ovf       (ovf_b_unused),
    .flag      (flag_B)
  );

  assign irq_n = irq_n_q;

endmodule
